// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings for the execute-stage multiply/divide unit.
// Contents: major opcode and M-extension funct7, funct3 operation codes,
// reset polarity, FSM state encoding and operand-signedness helpers.
package ex_muldiv_pkg;

    localparam logic [6:0] OP            = 7'b0110011;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] MUL_FUNCT3    = 3'b000;
    localparam logic [2:0] MULH_FUNCT3   = 3'b001;
    localparam logic [2:0] MULHSU_FUNCT3 = 3'b010;
    localparam logic [2:0] MULHU_FUNCT3  = 3'b011;
    localparam logic [2:0] DIV_FUNCT3    = 3'b100;
    localparam logic [2:0] DIVU_FUNCT3   = 3'b101;
    localparam logic [2:0] REM_FUNCT3    = 3'b110;
    localparam logic [2:0] REMU_FUNCT3   = 3'b111;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == MULH_FUNCT3) || (f3 == MULHSU_FUNCT3) ||
               (f3 == DIV_FUNCT3)  || (f3 == REM_FUNCT3);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == MULH_FUNCT3) || (f3 == DIV_FUNCT3) || (f3 == REM_FUNCT3);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX-side request and result bundle of the multiply/divide unit.
// master: pipeline side (drives aluop/funct3/funct7/reg1/reg2/annul).
// slave : ex_muldiv (drives stallreq_o, done_o, result_o, busy_o).
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic [6:0]      aluop_i;
    logic [2:0]      funct3_i;
    logic [6:0]      funct7_i;
    logic [XLEN-1:0] reg1_i;
    logic [XLEN-1:0] reg2_i;
    logic            annul_i;
    logic            stallreq_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output aluop_i, funct3_i, funct7_i, reg1_i, reg2_i, annul_i,
        input  stallreq_o, done_o, result_o, busy_o
    );

    modport slave (
        input  aluop_i, funct3_i, funct7_i, reg1_i, reg2_i, annul_i,
        output stallreq_o, done_o, result_o, busy_o
    );
endinterface

// File: rtl/ex_muldiv_signfix.sv
// ex_muldiv_signfix: sign handling around the unsigned iteration core.
// Front end: funct3_i/reg1_i/reg2_i -> mag1_o/mag2_o (operand magnitudes) and
//            neg_res_o (result must be negated).
// Back end : raw_i + neg_i -> fixed_o (two's complement applied when neg_i).
module ex_muldiv_signfix
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   reg1_i,
    input  logic [XLEN-1:0]   reg2_i,
    output logic [XLEN-1:0]   mag1_o,
    output logic [XLEN-1:0]   mag2_o,
    output logic              neg_res_o,
    input  logic [2*XLEN-1:0] raw_i,
    input  logic              neg_i,
    output logic [2*XLEN-1:0] fixed_o
);
    logic neg1, neg2;

    // The most negative value negates to itself, which is still the correct
    // unsigned magnitude.
    always_comb begin
        neg1      = op_signed_a(funct3_i) & reg1_i[XLEN-1];
        neg2      = op_signed_b(funct3_i) & reg2_i[XLEN-1];
        mag1_o    = neg1 ? -reg1_i : reg1_i;
        mag2_o    = neg2 ? -reg2_i : reg2_i;
        // Remainder follows the dividend; everything else follows the sign XOR.
        neg_res_o = (funct3_i == REM_FUNCT3) ? neg1 : (neg1 ^ neg2);
    end

    always_comb begin
        fixed_o = neg_i ? -raw_i : raw_i;
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the execute-stage ALU.
// Ports: clk, rst (synchronous, active-high),
//        bus (ex_muldiv_if.slave): aluop_i/funct3_i/funct7_i/reg1_i/reg2_i/annul_i
//        in; stallreq_o/done_o/result_o/busy_o out.
// Build option MULDIV_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed
// product instead of the shift-add loop; divides are unaffected.
//
// state   | meaning
// MD_IDLE | waiting for an M-extension request
// MD_CALC | one shift-add / restoring shift-subtract step per cycle
// MD_DONE | result_o valid, done_o high for this cycle only
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_step, raw_res, fixed_res;
    logic [XLEN-1:0]   opb_q, mag1, mag2, special_res, calc_res, result_q;
    logic [2:0]        f3_q;
    logic              neg_q, neg_res;
    logic              req, div_zero, div_ovf, special, fast, last_iter;
    logic              stall, done;
    logic [XLEN:0]     add_sum, rem_sh;
    logic [XLEN-1:0]   sub_diff;
    logic              rem_ge;

    ex_muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .funct3_i (bus.funct3_i),
        .reg1_i   (bus.reg1_i),
        .reg2_i   (bus.reg2_i),
        .mag1_o   (mag1),
        .mag2_o   (mag2),
        .neg_res_o(neg_res),
        .raw_i    (raw_res),
        .neg_i    (neg_q),
        .fixed_o  (fixed_res)
    );

    assign req       = (bus.aluop_i == OP) && (bus.funct7_i == MULDIV_FUNCT7);
    assign div_zero  = bus.funct3_i[2] && (bus.reg2_i == '0);
    assign div_ovf   = bus.funct3_i[2] && !bus.funct3_i[0] &&
                       (bus.reg1_i == MIN_NEG) && (bus.reg2_i == '1);
    assign special   = div_zero || div_ovf;
    assign last_iter = (cnt_q == LAST_CNT);

    // funct3[1] separates remainder from quotient among the divides.
    always_comb begin
        if (div_zero) begin
            special_res = bus.funct3_i[1] ? bus.reg1_i : '1;
        end else begin
            special_res = bus.funct3_i[1] ? '0 : MIN_NEG;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     ext1, ext2;
    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        ext1     = {op_signed_a(bus.funct3_i) & bus.reg1_i[XLEN-1], bus.reg1_i};
        ext2     = {op_signed_b(bus.funct3_i) & bus.reg2_i[XLEN-1], bus.reg2_i};
        prod     = ext1 * ext2;
        fast_res = (bus.funct3_i == MUL_FUNCT3) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign fast = !bus.funct3_i[2];
`else
    assign fast = 1'b0;
`endif

    // acc_q holds {partial product, remaining multiplier bits} for multiplies
    // and {partial remainder, dividend bits / quotient bits} for divides;
    // opb_q is the multiplicand or divisor magnitude.
    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opb_q} & {(XLEN+1){acc_q[0]}});
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_ge   = (rem_sh >= {1'b0, opb_q});
        // When rem_ge holds the true difference is below the divisor, so the
        // low XLEN bits of the subtraction are exact.
        sub_diff = rem_sh[XLEN-1:0] - opb_q;
        if (f3_q[2]) begin
            acc_step = {(rem_ge ? sub_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
            raw_res  = {{XLEN{1'b0}},
                        (f3_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0])};
        end else begin
            acc_step = {add_sum, acc_q[XLEN-1:1]};
            raw_res  = acc_step;
        end
    end

    assign calc_res = ((f3_q == MUL_FUNCT3) || f3_q[2]) ? fixed_res[XLEN-1:0]
                                                        : fixed_res[2*XLEN-1:XLEN];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = (special || fast) ? MD_DONE : MD_CALC;
                end
            end
            MD_CALC: begin
                stall = 1'b1;
                if (last_iter) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                done    = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (bus.annul_i) begin
            state_d = MD_IDLE;
            stall   = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (!bus.annul_i) begin
            case (state_q)
                MD_IDLE: begin
                    if (req) begin
                        f3_q  <= bus.funct3_i;
                        neg_q <= neg_res;
                        cnt_q <= '0;
                        opb_q <= bus.funct3_i[2] ? mag2 : mag1;
                        acc_q <= {{XLEN{1'b0}}, (bus.funct3_i[2] ? mag1 : mag2)};
                        if (special) begin
                            result_q <= special_res;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (fast) begin
                            result_q <= fast_res;
                        end
`endif
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_q <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stallreq_o = stall;
    assign bus.done_o     = done;
    assign bus.result_o   = result_q;
    assign bus.busy_o     = (state_q != MD_IDLE);

endmodule
